multi_alien_renderer: RTL

- Pipelined sprite-hit renderer that evaluates N_ALIENS aliens per pixel. For each pixel it returns the sprite ROM address and derivative (animation frame) select of the frontmost alien covering that pixel.
- Sits between the VGA timing counters and the alien sprite ROM / pixel mux.
- Adds over the single-alien combinational renderer: vertical bounds checking, depth priority, alive masking, per-frame shadow snapshot of object data, and a fixed 3-cycle registered pipeline.

---
 rtl/multi_alien_renderer.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/multi_alien_renderer.sv
// Three-stage sprite-hit renderer: per-pixel hit test over N_ALIENS shadowed aliens,
// depth-priority select of the frontmost hit, then sprite ROM address generation.
module multi_alien_renderer #(
    parameter int unsigned N_ALIENS    = 4,
    parameter int unsigned SPRITE_HALF = 32,
    parameter int unsigned R_W         = 5,
    parameter int unsigned DERIV_W     = 2,
    parameter int unsigned ADDR_W      = 11,
    localparam int unsigned ID_W       = (N_ALIENS > 1) ? $clog2(N_ALIENS) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    frame_start,
    input  logic                    pix_valid_in,
    input  logic [9:0]              h_cnt,
    input  logic [9:0]              v_cnt,
    input  logic [N_ALIENS-1:0]     alive,
    input  logic [N_ALIENS*10-1:0]  x_pos,
    input  logic [N_ALIENS*10-1:0]  y_pos,
    input  logic [N_ALIENS*R_W-1:0] r,
    input  logic [N_ALIENS*DERIV_W-1:0] deriv_left,
    input  logic [N_ALIENS*DERIV_W-1:0] deriv_right,
    output logic [ADDR_W-1:0]       pixel_addr,
    output logic [DERIV_W-1:0]      deriv_select,
    output logic [ID_W-1:0]         alien_id,
    output logic                    valid
);

    logic [N_ALIENS-1:0]         alive_q;
    logic [N_ALIENS*10-1:0]      x_q, y_q;
    logic [N_ALIENS*R_W-1:0]     r_q;
    logic [N_ALIENS*DERIV_W-1:0] dl_q, dr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            alive_q <= '0;
            x_q     <= '0;
            y_q     <= '0;
            r_q     <= '0;
            dl_q    <= '0;
            dr_q    <= '0;
        end else if (frame_start) begin
            alive_q <= alive;
            x_q     <= x_pos;
            y_q     <= y_pos;
            r_q     <= r;
            dl_q    <= deriv_left;
            dr_q    <= deriv_right;
        end
    end

    logic [N_ALIENS-1:0]         hit_c;
    logic [N_ALIENS*10-1:0]      dx_c;
    logic [N_ALIENS*12-1:0]      dv_c;
    logic [N_ALIENS*7-1:0]       hh_c;
    logic [N_ALIENS*DERIV_W-1:0] deriv_c;

    for (genvar gi = 0; gi < N_ALIENS; gi++) begin : g_alien
        logic [9:0]        x, y, dx;
        logic [R_W-1:0]    ri;
        logic [6:0]        hh;
        logic              side;
        logic signed [11:0] dv;

        assign x    = x_q[10*gi +: 10];
        assign y    = y_q[10*gi +: 10];
        assign ri   = r_q[R_W*gi +: R_W];
        assign hh   = (32'(ri) >= SPRITE_HALF) ? 7'd0 : 7'(SPRITE_HALF - 32'(ri));
        assign side = h_cnt < x;
        // Difference taken on the chosen side so dx never wraps near column 0
        assign dx   = side ? (x - h_cnt) : (h_cnt - x);
        assign dv   = $signed({2'b00, v_cnt}) - $signed({2'b00, y}) + $signed({5'b00000, hh});

        assign hit_c[gi] = pix_valid_in & alive_q[gi] & (hh != 7'd0) & ({3'b000, hh} > dx)
                         & ~dv[11] & (dv < $signed({4'b0000, hh, 1'b0}));
        assign dx_c[10*gi +: 10] = dx;
        assign dv_c[12*gi +: 12] = dv;
        assign hh_c[7*gi +: 7]   = hh;
        assign deriv_c[DERIV_W*gi +: DERIV_W] =
            side ? dl_q[DERIV_W*gi +: DERIV_W] : dr_q[DERIV_W*gi +: DERIV_W];
    end

    logic [N_ALIENS-1:0]         s1_hit_q;
    logic [N_ALIENS*10-1:0]      s1_dx_q;
    logic [N_ALIENS*12-1:0]      s1_dv_q;
    logic [N_ALIENS*7-1:0]       s1_hh_q;
    logic [N_ALIENS*R_W-1:0]     s1_r_q;
    logic [N_ALIENS*DERIV_W-1:0] s1_deriv_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_hit_q   <= '0;
            s1_dx_q    <= '0;
            s1_dv_q    <= '0;
            s1_hh_q    <= '0;
            s1_r_q     <= '0;
            s1_deriv_q <= '0;
        end else begin
            s1_hit_q   <= hit_c;
            s1_dx_q    <= dx_c;
            s1_dv_q    <= dv_c;
            s1_hh_q    <= hh_c;
            s1_r_q     <= r_q;
            s1_deriv_q <= deriv_c;
        end
    end

    logic               any_d, any_q;
    logic [R_W-1:0]     best_r;
    logic [ID_W-1:0]    id_d, id_q;
    logic [9:0]         dx_d, dx_q;
    logic [11:0]        dv_d, dv_q;
    logic [6:0]         hh_d, hh_q;
    logic [DERIV_W-1:0] deriv_d, deriv_q;

    // Strict less-than while scanning upward keeps the lowest index on equal depth
    always_comb begin
        any_d   = 1'b0;
        best_r  = '1;
        id_d    = '0;
        dx_d    = '0;
        dv_d    = '0;
        hh_d    = '0;
        deriv_d = '0;
        for (int i = 0; i < N_ALIENS; i++) begin
            if (s1_hit_q[i] && (!any_d || (s1_r_q[R_W*i +: R_W] < best_r))) begin
                any_d   = 1'b1;
                best_r  = s1_r_q[R_W*i +: R_W];
                id_d    = ID_W'(i);
                dx_d    = s1_dx_q[10*i +: 10];
                dv_d    = s1_dv_q[12*i +: 12];
                hh_d    = s1_hh_q[7*i +: 7];
                deriv_d = s1_deriv_q[DERIV_W*i +: DERIV_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            any_q   <= 1'b0;
            id_q    <= '0;
            dx_q    <= '0;
            dv_q    <= '0;
            hh_q    <= '0;
            deriv_q <= '0;
        end else begin
            any_q   <= any_d;
            id_q    <= id_d;
            dx_q    <= dx_d;
            dv_q    <= dv_d;
            hh_q    <= hh_d;
            deriv_q <= deriv_d;
        end
    end

    logic [18:0] addr_full;
    assign addr_full = 19'(dv_q) * 19'(hh_q) + 19'(dx_q);

    always_ff @(posedge clk) begin
        if (rst || !any_q) begin
            pixel_addr   <= '0;
            deriv_select <= '0;
            alien_id     <= '0;
            valid        <= 1'b0;
        end else begin
            pixel_addr   <= ADDR_W'(addr_full);
            deriv_select <= deriv_q;
            alien_id     <= id_q;
            valid        <= 1'b1;
        end
    end

endmodule
